snell_refract: RTL and testbench

- Inverse companion to the refractive-index solver. Takes n1, n2 (q2.2) and incidence angle theta1 (integer degrees) and computes the refraction angle theta2 = asin(n1*sin(theta1)/n2) in integer degrees.
- Flags total internal reflection and illegal operands.
- Uses the same shared 7-bit load/readback port and select-line protocol.
- Multi-cycle: one multiply cycle, a 12-step restoring divider, then a 7-step binary-search arcsin over an internal sine ROM.

---
 rtl/snell_refract.sv | 255 +++++++++++++++++++++++++
 tb/tb_snell_refract.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/snell_refract.sv
// snell_refract: computes the refraction angle theta2 = asin(n1*sin(theta1)/n2)
// in integer degrees from n1, n2 (q2.2) and theta1 (integer degrees).
//
// Flow: IDLE -> MUL (n1*SIN[theta1]) -> DIV (12-step restoring divide by n2,
// quotient is q1.8) -> ASIN (7-step binary search over the sine ROM) -> DONE.
// Illegal operands (n2==0 or theta1>ANGLE_MAX) skip straight from MUL to DONE
// with err set; a quotient above 1.0 skips ASIN with tir set.
//
// Optional build macro ASIN_NEAREST_EN adds a ROUND state after ASIN that
// moves the result to d+1 when SIN[d+1] is strictly closer to the quotient.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   n1_sel       load n1 from input_port[3:0]
//   n2_sel       load n2 from input_port[3:0]
//   t1_sel       load theta1 from input_port[6:0]
//   out_sel      drive theta2 onto output_port
//   start        begin a computation (sampled in IDLE only)
//   input_port   shared 7-bit operand input
//   output_port  registered readback / result
//   busy         high while computing (not IDLE/DONE)
//   done         one-cycle completion pulse
//   tir          total internal reflection on the last run
//   err          illegal operands on the last run
module snell_refract #(
  parameter int ANGLE_MAX  = 90,
  parameter int TIR_RESULT = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       n1_sel,
  input  logic       n2_sel,
  input  logic       t1_sel,
  input  logic       out_sel,
  input  logic       start,
  input  logic [6:0] input_port,
  output logic [6:0] output_port,
  output logic       busy,
  output logic       done,
  output logic       tir,
  output logic       err
);

  localparam logic [6:0] ANG_MAX7 = 7'(ANGLE_MAX);
  localparam logic [6:0] TIR7     = 7'(TIR_RESULT);

`ifdef ASIN_NEAREST_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, ASIN, ROUND, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL, DIV, ASIN, DONE} state_t;
`endif

  // SIN[d] = round(256*sin(d deg)), q1.8. Entries above 90 are never used.
  function automatic logic [8:0] sin_rom(input logic [6:0] d);
    logic [8:0] v;
    v = 9'h1FF;
    case (d)
      7'd0:  v = 9'd0;   7'd1:  v = 9'd4;   7'd2:  v = 9'd9;   7'd3:  v = 9'd13;
      7'd4:  v = 9'd18;  7'd5:  v = 9'd22;  7'd6:  v = 9'd27;  7'd7:  v = 9'd31;
      7'd8:  v = 9'd36;  7'd9:  v = 9'd40;  7'd10: v = 9'd44;  7'd11: v = 9'd49;
      7'd12: v = 9'd53;  7'd13: v = 9'd58;  7'd14: v = 9'd62;  7'd15: v = 9'd66;
      7'd16: v = 9'd71;  7'd17: v = 9'd75;  7'd18: v = 9'd79;  7'd19: v = 9'd83;
      7'd20: v = 9'd88;  7'd21: v = 9'd92;  7'd22: v = 9'd96;  7'd23: v = 9'd100;
      7'd24: v = 9'd104; 7'd25: v = 9'd108; 7'd26: v = 9'd112; 7'd27: v = 9'd116;
      7'd28: v = 9'd120; 7'd29: v = 9'd124; 7'd30: v = 9'd128; 7'd31: v = 9'd132;
      7'd32: v = 9'd136; 7'd33: v = 9'd139; 7'd34: v = 9'd143; 7'd35: v = 9'd147;
      7'd36: v = 9'd150; 7'd37: v = 9'd154; 7'd38: v = 9'd158; 7'd39: v = 9'd161;
      7'd40: v = 9'd165; 7'd41: v = 9'd168; 7'd42: v = 9'd171; 7'd43: v = 9'd175;
      7'd44: v = 9'd178; 7'd45: v = 9'd181; 7'd46: v = 9'd184; 7'd47: v = 9'd187;
      7'd48: v = 9'd190; 7'd49: v = 9'd193; 7'd50: v = 9'd196; 7'd51: v = 9'd199;
      7'd52: v = 9'd202; 7'd53: v = 9'd204; 7'd54: v = 9'd207; 7'd55: v = 9'd210;
      7'd56: v = 9'd212; 7'd57: v = 9'd215; 7'd58: v = 9'd217; 7'd59: v = 9'd219;
      7'd60: v = 9'd222; 7'd61: v = 9'd224; 7'd62: v = 9'd226; 7'd63: v = 9'd228;
      7'd64: v = 9'd230; 7'd65: v = 9'd232; 7'd66: v = 9'd234; 7'd67: v = 9'd236;
      7'd68: v = 9'd237; 7'd69: v = 9'd239; 7'd70: v = 9'd241; 7'd71: v = 9'd242;
      7'd72: v = 9'd243; 7'd73: v = 9'd245; 7'd74: v = 9'd246; 7'd75: v = 9'd247;
      7'd76: v = 9'd248; 7'd77: v = 9'd249; 7'd78: v = 9'd250; 7'd79: v = 9'd251;
      7'd80: v = 9'd252; 7'd81: v = 9'd253; 7'd82: v = 9'd254; 7'd83: v = 9'd254;
      7'd84: v = 9'd255; 7'd85: v = 9'd255; 7'd86: v = 9'd255; 7'd87: v = 9'd256;
      7'd88: v = 9'd256; 7'd89: v = 9'd256; 7'd90: v = 9'd256;
      default: v = 9'h1FF;
    endcase
    return v;
  endfunction

`ifdef ASIN_NEAREST_EN
  // d is the floor arcsin of q, so SIN[d] <= q < SIN[d+1]; ties keep d.
  function automatic logic [6:0] round_nearest(input logic [6:0] d, input logic [8:0] q);
    logic [8:0] lo;
    logic [8:0] hi;
    logic [6:0] r;
    lo = 9'd0;
    hi = 9'd0;
    r  = d;
    if (d < 7'd90) begin
      lo = q - sin_rom(d);
      hi = sin_rom(d + 7'd1) - q;
      if (hi < lo) r = d + 7'd1;
    end
    return r;
  endfunction
`endif

  state_t      state, state_n;
  logic [3:0]  n1_q, n2_q;
  logic [6:0]  t1_q, theta2_q;
  logic [3:0]  cnt;
  logic [6:0]  bit_m;

  // Iterative datapath working registers (not reset: always seeded in MUL/DIV)
  logic [11:0] dvd;
  logic [3:0]  rem;
  logic [11:0] quo;
  logic [8:0]  q_val;
  logic [6:0]  res;

  logic        bad_op;
  logic [11:0] prod_w;
  logic [4:0]  trial;
  logic        ge;
  logic [3:0]  rem_nxt;
  logic [11:0] quo_nxt;
  logic        div_last;
  logic        q_over;
  logic [6:0]  cand;
  logic        keep;
  logic [6:0]  res_nxt;

  assign busy     = (state != IDLE) && (state != DONE);
  assign bad_op   = (n2_q == 4'd0) || (t1_q > ANG_MAX7);
  assign prod_w   = {8'd0, n1_q} * {3'd0, sin_rom(t1_q)};

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  assign trial    = {rem, dvd[11]};
  assign ge       = trial >= {1'b0, n2_q};
  assign rem_nxt  = ge ? 4'(trial - {1'b0, n2_q}) : trial[3:0];
  assign quo_nxt  = {quo[10:0], ge};
  assign div_last = (cnt == 4'd11);
  assign q_over   = quo_nxt > 12'd256;

  // One arcsin search step: try setting the current bit of the angle
  assign cand     = res | bit_m;
  assign keep     = (cand <= 7'd90) && (sin_rom(cand) <= q_val);
  assign res_nxt  = keep ? cand : res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = MUL;
      MUL:  state_n = bad_op ? DONE : DIV;
      DIV:  if (div_last) state_n = q_over ? DONE : ASIN;
`ifdef ASIN_NEAREST_EN
      ASIN:  if (bit_m[0]) state_n = ROUND;
      ROUND: state_n = DONE;
`else
      ASIN: if (bit_m[0]) state_n = DONE;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand registers and readback port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n1_q        <= 4'd0;
      n2_q        <= 4'd0;
      t1_q        <= 7'd0;
      output_port <= 7'd0;
    end else if (n1_sel) begin
      output_port <= {3'd0, n1_q};
      if (!busy) n1_q <= input_port[3:0];
    end else if (n2_sel) begin
      output_port <= {3'd0, n2_q};
      if (!busy) n2_q <= input_port[3:0];
    end else if (t1_sel) begin
      output_port <= t1_q;
      if (!busy) t1_q <= input_port;
    end else if (out_sel) begin
      output_port <= theta2_q;
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 4'd0;
      bit_m    <= 7'd0;
      theta2_q <= 7'd0;
      tir      <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          tir <= 1'b0;
          err <= 1'b0;
        end
        MUL: begin
          cnt <= 4'd0;
          if (bad_op) err <= 1'b1;
        end
        DIV: begin
          cnt <= cnt + 4'd1;
          if (div_last) begin
            bit_m <= 7'b1000000;
            if (q_over) begin
              tir      <= 1'b1;
              theta2_q <= TIR7;
            end
          end
        end
        ASIN: begin
          bit_m <= bit_m >> 1;
          if (bit_m[0]) theta2_q <= res_nxt;
        end
`ifdef ASIN_NEAREST_EN
        ROUND: theta2_q <= round_nearest(theta2_q, q_val);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      // MUL -> DIV: seed the divider with the product
      MUL: begin
        dvd <= prod_w;
        rem <= 4'd0;
        quo <= 12'd0;
      end
      // DIV -> ASIN: capture the q1.8 quotient, clear the search angle
      DIV: begin
        dvd <= {dvd[10:0], 1'b0};
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (div_last) begin
          q_val <= quo_nxt[8:0];
          res   <= 7'd0;
        end
      end
      ASIN: res <= res_nxt;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snell_refract.sv
module tb_snell_refract;

`ifdef ASIN_NEAREST_EN
  localparam int LAT_N = 22;
`else
  localparam int LAT_N = 21;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       n1_sel = 1'b0, n2_sel = 1'b0, t1_sel = 1'b0, out_sel = 1'b0;
  logic       start = 1'b0;
  logic [6:0] input_port = 7'd0;
  logic [6:0] output_port;
  logic       busy, done, tir, err;

  snell_refract dut (
    .clk(clk), .rst(rst), .n1_sel(n1_sel), .n2_sel(n2_sel), .t1_sel(t1_sel),
    .out_sel(out_sel), .start(start), .input_port(input_port),
    .output_port(output_port), .busy(busy), .done(done), .tir(tir), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [6:0] val; string name; } rb_t;
  typedef struct { int cyc; logic tir; logic err; string name; } dn_t;

  rb_t rb_q[$];
  dn_t dn_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  task automatic note_fail(input string nm);
    total_cnt++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compares readbacks and completion events against the queues
  rb_t mr;
  dn_t md;
  initial begin
    forever begin
      @(negedge clk);
      if (rb_q.size() > 0 && rb_q[0].cyc <= cyc) begin
        mr = rb_q.pop_front();
        chk(mr.name, int'(output_port), int'(mr.val));
      end
      if (done) begin
        if (dn_q.size() == 0) note_fail("spurious_done");
        else begin
          md = dn_q.pop_front();
          chk({md.name, "_latency_cycle"}, cyc, md.cyc);
          chk({md.name, "_tir"}, int'(tir), int'(md.tir));
          chk({md.name, "_err"}, int'(err), int'(md.err));
        end
      end else if (dn_q.size() > 0 && cyc > dn_q[0].cyc) begin
        md = dn_q.pop_front();
        note_fail({md.name, "_done_missing"});
      end
    end
  end

  // which: 0 n1, 1 n2, 2 theta1, 3 out_sel readback
  task automatic sel_op(input int which, input logic [6:0] v, input logic [6:0] expv,
                        input string nm);
    rb_t r;
    @(negedge clk);
    n1_sel = (which == 0);
    n2_sel = (which == 1);
    t1_sel = (which == 2);
    out_sel = (which == 3);
    input_port = v;
    r.cyc = cyc + 1; r.val = expv; r.name = nm;
    rb_q.push_back(r);
    @(negedge clk);
    n1_sel = 1'b0; n2_sel = 1'b0; t1_sel = 1'b0; out_sel = 1'b0;
  endtask

  task automatic kick(input string nm, input logic etir, input logic eerr, input int lat);
    dn_t d;
    @(negedge clk);
    start = 1'b1;
    d.cyc = cyc + 1 + lat; d.tir = etir; d.err = eerr; d.name = nm;
    dn_q.push_back(d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && dn_q.size() > 0; i++) @(negedge clk);
    if (dn_q.size() > 0) begin
      note_fail("wait_done_budget");
      dn_q.delete();
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_output_port", int'(output_port), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tir", int'(tir), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;

    // 4,4,30 -> Q=128 -> 30
    sel_op(0, 7'd4, 7'd0, "n1_echo_0");
    sel_op(1, 7'd4, 7'd0, "n2_echo_0");
    sel_op(2, 7'd30, 7'd0, "t1_echo_0");
    kick("run30", 1'b0, 1'b0, LAT_N); wait_done();
    sel_op(3, 7'd0, 7'd30, "theta2_30");

    // 4,6,60 -> P=888 Q=148 -> 35
    sel_op(1, 7'd6, 7'd4, "n2_echo_4");
    sel_op(2, 7'd60, 7'd30, "t1_echo_30");
    kick("run35", 1'b0, 1'b0, LAT_N); wait_done();
    sel_op(3, 7'd0, 7'd35, "theta2_35");

    // 6,4,60 -> Q=333 -> TIR, 90
    sel_op(0, 7'd6, 7'd4, "n1_echo_4");
    sel_op(1, 7'd4, 7'd6, "n2_echo_6");
    kick("tir", 1'b1, 1'b0, 14); wait_done();
    sel_op(3, 7'd0, 7'd90, "theta2_tir");

    // n2=0 -> err, theta2 kept
    sel_op(1, 7'd0, 7'd4, "n2_echo_4b");
    kick("err_n2", 1'b0, 1'b1, 2); wait_done();
    sel_op(3, 7'd0, 7'd90, "theta2_kept_n2");

    // theta1=95 -> err
    sel_op(1, 7'd4, 7'd0, "n2_echo_0b");
    sel_op(2, 7'd95, 7'd60, "t1_echo_60");
    kick("err_t1", 1'b0, 1'b1, 2); wait_done();
    chk("err_hold", int'(err), 1);
    sel_op(3, 7'd0, 7'd90, "theta2_kept_t1");

    // theta1=0 -> 0
    sel_op(2, 7'd0, 7'd95, "t1_echo_95");
    kick("zero", 1'b0, 1'b0, LAT_N); wait_done();
    sel_op(3, 7'd0, 7'd0, "theta2_0");

    // 4,4,90 -> Q=256, not TIR -> 90
    sel_op(0, 7'd4, 7'd6, "n1_echo_6");
    sel_op(2, 7'd90, 7'd0, "t1_echo_0b");
    kick("q256", 1'b0, 1'b0, LAT_N); wait_done();
    sel_op(3, 7'd0, 7'd90, "theta2_q256");

    // TIR again, flag holds
    sel_op(0, 7'd6, 7'd4, "n1_echo_4c");
    sel_op(2, 7'd60, 7'd90, "t1_echo_90");
    kick("tir2", 1'b1, 1'b0, 14); wait_done();
    repeat (3) @(negedge clk);
    chk("tir_hold", int'(tir), 1);

    // Abort with reset during DIV
    kick("abort", 1'b1, 1'b0, 14);
    sel_op(3, 7'd0, 7'd90, "readback_while_busy");
    @(negedge clk);
    chk("busy_in_div", int'(busy), 1);
    rst = 1'b0;
    dn_q.delete();
    #1;
    chk("abort_output_port", int'(output_port), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_tir", int'(tir), 0);
    chk("abort_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);

    // Registers cleared; start and load while busy are ignored
    sel_op(0, 7'd4, 7'd0, "n1_after_rst");
    sel_op(1, 7'd6, 7'd0, "n2_after_rst");
    sel_op(2, 7'd60, 7'd0, "t1_after_rst");
    kick("busy_ign", 1'b0, 1'b0, LAT_N);
    @(negedge clk);
    begin
      rb_t r;
      t1_sel = 1'b1; start = 1'b1; input_port = 7'd10;
      r.cyc = cyc + 1; r.val = 7'd60; r.name = "t1_echo_busy";
      rb_q.push_back(r);
      @(negedge clk);
      t1_sel = 1'b0; start = 1'b0;
    end
    wait_done();
    repeat (25) @(negedge clk);
    sel_op(2, 7'd0, 7'd60, "t1_unchanged_busy");
    sel_op(3, 7'd0, 7'd35, "theta2_busy_ign");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
